// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the iterative divider slice.
//                divOp_t     - RV M-extension divide opcode (op[1]=remainder,
//                              op[0]=unsigned)
//                divState_t  - control FSM state encoding
//                c_all_ones  - divide-by-zero quotient pattern (widest case)
//                most_neg()  - most-negative two's-complement value of a
//                              given width, zero-extended to c_max_width
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } divOp_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } divState_t;

    localparam int c_max_width = 64;

    localparam logic [c_max_width-1:0] c_all_ones = '1;

    function automatic logic [c_max_width-1:0] most_neg(input int width);
        return {{(c_max_width-1){1'b0}}, 1'b1} << (width - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_restoring_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_restoring_step
//  Description : One radix-2 restoring division step (pure combinational).
//                {rem, quo} is shifted left by one, the divisor is trial-
//                subtracted from the shifted remainder, and the difference is
//                kept (quotient LSB = 1) when it is non-negative.
//  Ports       : rem_in   [BIT_COUNT:0]   partial remainder
//                quo_in   [BIT_COUNT-1:0] partial quotient / dividend bits
//                divisor  [BIT_COUNT-1:0] magnitude of divisor
//                rem_out  [BIT_COUNT:0]   next partial remainder
//                quo_out  [BIT_COUNT-1:0] next partial quotient
//  Revision    : 1.0 - initial release
// ============================================================================
module div_restoring_step #(
    parameter int BIT_COUNT = 32
) (
    input  logic [BIT_COUNT:0]   rem_in,
    input  logic [BIT_COUNT-1:0] quo_in,
    input  logic [BIT_COUNT-1:0] divisor,
    output logic [BIT_COUNT:0]   rem_out,
    output logic [BIT_COUNT-1:0] quo_out
);

    logic [BIT_COUNT:0]   w_shifted;
    logic [BIT_COUNT+1:0] w_diff;
    logic                 w_nonneg;
    logic                 w_unused;

    // The partial remainder is always below the divisor, so its top bit is
    // zero on entry and the shifted value fits in BIT_COUNT+1 bits. One extra
    // bit on the difference carries the borrow.
    assign w_shifted = {rem_in[BIT_COUNT-1:0], quo_in[BIT_COUNT-1]};
    assign w_diff    = {1'b0, w_shifted} - {2'b00, divisor};
    assign w_nonneg  = ~w_diff[BIT_COUNT+1];

    assign rem_out   = w_nonneg ? w_diff[BIT_COUNT:0] : w_shifted;
    assign quo_out   = {quo_in[BIT_COUNT-2:0], w_nonneg};

    assign w_unused  = rem_in[BIT_COUNT];

endmodule
`default_nettype wire

// File: rtl/iterative_divider.sv
`default_nettype none
// ============================================================================
//  Module      : iterative_divider
//  Description : Multi-cycle radix-2 restoring divider for RV DIV/DIVU/REM/
//                REMU. BIT_COUNT RUN cycles plus one FIX cycle for normal
//                operands; divide-by-zero and signed overflow finish directly.
//  Ports       : clk     - clock, rising edge
//                reset   - asynchronous reset, active low
//                start   - request, accepted when start && ready && !flush
//                op      - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//                Rs1/Rs2 - dividend / divisor, sampled at accept
//                flush   - abort, returns to IDLE on the next edge
//                ready   - IDLE or DONE
//                busy    - RUN or FIX
//                done    - one-cycle pulse in DONE
//                Result  - quotient or remainder, held until the next DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module iterative_divider
    import div_pkg::*;
#(
    parameter int BIT_COUNT = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [BIT_COUNT-1:0] Rs1,
    input  logic [BIT_COUNT-1:0] Rs2,
    input  logic                 flush,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [BIT_COUNT-1:0] Result
);

    localparam int                     c_cnt_w         = $clog2(BIT_COUNT);
    localparam logic [c_max_width-1:0] c_most_neg_wide = most_neg(BIT_COUNT);
    localparam logic [BIT_COUNT-1:0]   c_most_neg      = c_most_neg_wide[BIT_COUNT-1:0];
    localparam logic [BIT_COUNT-1:0]   c_ones          = c_all_ones[BIT_COUNT-1:0];

    divState_t              r_state;
    divOp_t                 r_op;
    logic                   r_neg_q;
    logic                   r_neg_r;
    logic [BIT_COUNT:0]     r_rem;
    logic [BIT_COUNT-1:0]   r_quo;
    logic [BIT_COUNT-1:0]   r_div;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [BIT_COUNT-1:0]   r_result;

    divOp_t                 w_op;
    logic                   w_signed;
    logic                   w_is_rem;
    logic                   w_a_neg;
    logic                   w_b_neg;
    logic                   w_div_zero;
    logic                   w_overflow;
    logic [BIT_COUNT-1:0]   w_special;
    logic [BIT_COUNT:0]     w_next_rem;
    logic [BIT_COUNT-1:0]   w_next_quo;
    logic [BIT_COUNT-1:0]   w_quo_fixed;
    logic [BIT_COUNT-1:0]   w_rem_fixed;

    // ------------------------------------------------------------------
    // Operand decode at accept time
    // ------------------------------------------------------------------
    assign w_op       = divOp_t'(op);
    assign w_signed   = (w_op == DIV) || (w_op == REM);
    assign w_is_rem   = (w_op == REM) || (w_op == REMU);
    assign w_a_neg    = w_signed && Rs1[BIT_COUNT-1];
    assign w_b_neg    = w_signed && Rs2[BIT_COUNT-1];
    assign w_div_zero = (Rs2 == '0);
    assign w_overflow = w_signed && (Rs1 == c_most_neg) && (Rs2 == c_ones);

    always_comb begin
        w_special = '0;
        if (w_div_zero) begin
            w_special = w_is_rem ? Rs1 : c_ones;
        end else if (w_overflow) begin
            w_special = w_is_rem ? '0 : Rs1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: single restoring step iterated by the FSM
    // ------------------------------------------------------------------
    div_restoring_step #(
        .BIT_COUNT (BIT_COUNT)
    ) u_step (
        .rem_in    (r_rem),
        .quo_in    (r_quo),
        .divisor   (r_div),
        .rem_out   (w_next_rem),
        .quo_out   (w_next_quo)
    );

    assign w_quo_fixed = r_neg_q ? -r_quo : r_quo;
    assign w_rem_fixed = r_neg_r ? -r_rem[BIT_COUNT-1:0] : r_rem[BIT_COUNT-1:0];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_op     <= DIV;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (flush) begin
            r_state  <= IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_op    <= w_op;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_rem   <= '0;
                        r_quo   <= w_a_neg ? -Rs1 : Rs1;
                        r_div   <= w_b_neg ? -Rs2 : Rs2;
                        r_cnt   <= c_cnt_w'(BIT_COUNT - 1);
                        if (w_div_zero || w_overflow) begin
                            r_result <= w_special;
                            r_state  <= DONE;
                        end else begin
                            r_state  <= RUN;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_rem <= w_next_rem;
                    r_quo <= w_next_quo;
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                FIX: begin
                    r_result <= ((r_op == REM) || (r_op == REMU)) ? w_rem_fixed : w_quo_fixed;
                    r_state  <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Status flags are pure decodes of the state register, so an
    // asynchronous reset is reflected on them immediately.
    assign ready  = (r_state == IDLE) || (r_state == DONE);
    assign busy   = (r_state == RUN)  || (r_state == FIX);
    assign done   = (r_state == DONE);
    assign Result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_iterative_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iterative_divider
//  Description : Self-checking bench for iterative_divider (BIT_COUNT = 32).
//                Directed vector table, randomized operands against an
//                arithmetic reference model, and hand-written sequences for
//                flush, back-to-back issue and asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iterative_divider;

    localparam int BW = 32;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;
    localparam int NORMAL_LAT  = BW + 2;
    localparam int SPECIAL_LAT = 1;

    logic          clk;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [BW-1:0] Rs1;
    logic [BW-1:0] Rs2;
    logic          flush;
    logic          ready;
    logic          busy;
    logic          done;
    logic [BW-1:0] Result;

    int checks;
    int errors;

    iterative_divider #(
        .BIT_COUNT (BW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .Rs1    (Rs1),
        .Rs2    (Rs2),
        .flush  (flush),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .Result (Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    o;
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        logic [BW-1:0] exp_res;
        int            exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: RISC-V M-extension divide semantics in plain arithmetic.
    function automatic logic [BW-1:0] model(input logic [1:0] o, input logic [BW-1:0] a, input logic [BW-1:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic            is_rem;
        logic            is_signed;
        is_rem    = (o == OP_REM) || (o == OP_REMU);
        is_signed = (o == OP_DIV) || (o == OP_REM);
        if (b == 0) return is_rem ? a : {BW{1'b1}};
        if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? '0 : a;
        if (is_signed) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return is_rem ? BW'(sa % sb) : BW'(sa / sb);
        end
        ua = longint'(a);
        ub = longint'(b);
        return is_rem ? BW'(ua % ub) : BW'(ua / ub);
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [BW-1:0] a, input logic [BW-1:0] b);
        if (b == 0) return SPECIAL_LAT;
        if ((o == OP_DIV || o == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return SPECIAL_LAT;
        return NORMAL_LAT;
    endfunction

    // Called at a negedge; returns at the negedge of cycle 1 after accept.
    // Operands are scrambled afterwards to show they are not re-sampled.
    task automatic issue(input logic [1:0] o, input logic [BW-1:0] a, input logic [BW-1:0] b);
        op    = o;
        Rs1   = a;
        Rs2   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        Rs1   = $urandom;
        Rs2   = $urandom;
        op    = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_done(input string name, output int lat);
        lat = 1;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no done after %0d cycles, expected done", name, lat);
        end
    endtask

    task automatic run_vec(input string name, input logic [1:0] o, input logic [BW-1:0] a,
                           input logic [BW-1:0] b, input logic [BW-1:0] er, input int el);
        int lat;
        @(negedge clk);
        issue(o, a, b);
        wait_done(name, lat);
        check({name, " latency"}, 64'(lat), 64'(el));
        check({name, " result"}, 64'(Result), 64'(er));
    endtask

    initial begin
        logic [BW-1:0] last_exp;
        logic [1:0]    ro;
        logic [BW-1:0] ra, rb;
        int            lat;
        int            seen_done;

        checks = 0;
        errors = 0;
        reset  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        op     = 2'b00;
        Rs1    = '0;
        Rs2    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset ready",  64'(ready),  64'd1);
        check("reset busy",   64'(busy),   64'd0);
        check("reset done",   64'(done),   64'd0);
        check("reset result", 64'(Result), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed table
        vecs.push_back('{OP_DIVU, 32'd100,        32'd7,          32'd14,         NORMAL_LAT});
        vecs.push_back('{OP_REMU, 32'd100,        32'd7,          32'd2,          NORMAL_LAT});
        vecs.push_back('{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  NORMAL_LAT});
        vecs.push_back('{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  NORMAL_LAT});
        vecs.push_back('{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  NORMAL_LAT});
        vecs.push_back('{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          NORMAL_LAT});
        vecs.push_back('{OP_DIVU, 32'h1234,       32'd0,          32'hFFFF_FFFF,  SPECIAL_LAT});
        vecs.push_back('{OP_REMU, 32'h1234,       32'd0,          32'h1234,       SPECIAL_LAT});
        vecs.push_back('{OP_DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  SPECIAL_LAT});
        vecs.push_back('{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  SPECIAL_LAT});
        vecs.push_back('{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          SPECIAL_LAT});
        vecs.push_back('{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          NORMAL_LAT});
        vecs.push_back('{OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  NORMAL_LAT});
        vecs.push_back('{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  NORMAL_LAT});
        vecs.push_back('{OP_REM,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  NORMAL_LAT});
        foreach (vecs[i]) begin
            run_vec($sformatf("vec%0d", i), vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_lat);
        end

        // Randomized against the reference model
        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       begin rb = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) ra = 32'h8000_0000; end
                2:       rb = 32'($urandom_range(1, 20));
                3:       rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_vec($sformatf("rnd%0d op%0d 0x%0h/0x%0h", i, ro, ra, rb), ro, ra, rb,
                    model(ro, ra, rb), model_lat(ro, ra, rb));
        end

        // Back-to-back: new start accepted while the previous done pulses
        @(negedge clk);
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done("b2b first", lat);
        check("b2b first result", 64'(Result), 64'd14);
        issue(OP_DIVU, 32'd9, 32'd2);
        check("b2b no bubble busy", 64'(busy), 64'd1);
        check("b2b no bubble done", 64'(done), 64'd0);
        wait_done("b2b second", lat);
        check("b2b second latency", 64'(lat), 64'(NORMAL_LAT));
        check("b2b second result", 64'(Result), 64'd4);
        last_exp = 32'd4;

        // Flush in RUN cycle 10
        @(negedge clk);
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        check("flush pre busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush ready", 64'(ready), 64'd1);
        check("flush busy",  64'(busy),  64'd0);
        check("flush done",  64'(done),  64'd0);
        check("flush result", 64'(Result), 64'(last_exp));
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("flush no late done", 64'(seen_done), 64'd0);
        run_vec("after flush", OP_DIVU, 32'd50, 32'd5, 32'd10, NORMAL_LAT);

        // Flush and start in the same cycle: start is dropped
        @(negedge clk);
        op = OP_DIVU; Rs1 = 32'd77; Rs2 = 32'd7;
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush+start busy", 64'(busy), 64'd0);
        check("flush+start done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        check("flush+start idle", 64'(busy), 64'd0);
        check("flush+start result", 64'(Result), 64'd10);

        // Flush during DONE: done already high, start is dropped
        @(negedge clk);
        issue(OP_REMU, 32'd100, 32'd7);
        wait_done("flush-done op", lat);
        check("flush-done done high", 64'(done), 64'd1);
        op = OP_DIVU; Rs1 = 32'd9; Rs2 = 32'd2;
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush-done busy", 64'(busy), 64'd0);
        check("flush-done done", 64'(done), 64'd0);
        check("flush-done result", 64'(Result), 64'd2);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        issue(OP_DIVU, 32'd12345, 32'd17);
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async reset ready",  64'(ready),  64'd1);
        check("async reset busy",   64'(busy),   64'd0);
        check("async reset done",   64'(done),   64'd0);
        check("async reset result", 64'(Result), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_vec("after reset", OP_REMU, 32'd12345, 32'd17, 32'd3, NORMAL_LAT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/iterative_divider.md
Name: iterative_divider

Overview:
- Multi-cycle radix-2 restoring divider for the RV32M/RV64M DIV, DIVU, REM and REMU instructions.
- Sits in the execute stage, directly downstream of the register file. It consumes the Rs1 (dividend) and Rs2 (divisor) operand values read there.
- Its result returns through the normal writeback path to the register file write port.
- The pipeline stalls on ready/busy and captures Result when done pulses.

Parameters:
BIT_COUNT, 32, operand/result width (32 or 64)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request; accepted on an edge where start && ready && !flush
op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled at accept
Rs1  input  BIT_COUNT  dividend; sampled at accept
Rs2  input  BIT_COUNT  divisor; sampled at accept
flush  input  1  abort any operation in progress
ready  output  1  high in IDLE or DONE; a new start may be accepted
busy  output  1  high in RUN or FIX
done  output  1  one-cycle pulse, high only in DONE
Result  output  BIT_COUNT  quotient or remainder; stable from DONE until the next DONE

Behaviour:
- Reset (async, reset=0): state IDLE, ready=1, busy=0, done=0, Result=0, internal registers 0. This applies immediately, including mid-operation.
- States:
  - IDLE: accept -> RUN, or -> DONE on a special case.
  - RUN: holds for exactly BIT_COUNT cycles, iteration counter counting BIT_COUNT-1 down to 0, then -> FIX.
  - FIX: sign correction and Result load -> DONE.
  - DONE: done=1 for one cycle. Accept -> RUN (or DONE on a special case); otherwise -> IDLE.
- Accept latches op, the sign flags, and the absolute values of the operands. Absolute values apply only for signed ops; unsigned ops use operands as-is.
- Each RUN cycle is one restoring step: shift {remainder, quotient} left by 1, trial-subtract the divisor, keep the difference and set the quotient LSB if the difference is non-negative. The remainder register is BIT_COUNT+1 bits.
- FIX:
  - Signed quotient is negated if dividend and divisor signs differ.
  - Signed remainder takes the dividend's sign.
  - Result = quotient for DIV/DIVU, remainder for REM/REMU.
- Latency: accept on edge E. Normal ops: done is high in the (BIT_COUNT+2)th cycle after E (34 for BIT_COUNT=32).
- Special cases skip RUN/FIX. Result is loaded at E and done is high in the first cycle after E.
  - Divisor zero: DIV/DIVU -> all ones; REM/REMU -> dividend.
  - Signed overflow (DIV/REM with dividend = most-negative value and divisor = -1): DIV -> dividend; REM -> 0.
- Back-to-back: start in DONE is accepted. done pulses for the old result while the new operation starts; there are no idle bubbles.
- start while busy is ignored; no queueing.
- Flush:
  - Any state -> IDLE on the next edge. done stays 0 on that edge; Result is unchanged.
  - Flush has priority over a same-cycle start.
  - Flush in DONE still shows done=1 for that cycle, since it is already asserted.
- Result updates only on entry to DONE.
- Operand changes after accept have no effect.

Decomposition:
- Shared package div_pkg holds:
  - enum divOp_t {DIV, DIVU, REM, REMU}
  - enum divState_t {IDLE, RUN, FIX, DONE}
  - constant encodings for the special-case results (all-ones, most-negative)
- One combinational sub-module, div_restoring_step: inputs partial remainder, quotient and divisor; outputs the next remainder and quotient. It is instantiated once and the control FSM iterates it.

Test Plan:
1. DIVU 100/7 -> Result=14, done in cycle 34 after accept; REMU 100/7 -> 2.
2. DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIV 7/-2 -> -3; REM 7/-2 -> 1.
3. DIVU 0x1234/0 -> 0xFFFFFFFF, done in cycle 1 after accept; REMU 0x1234/0 -> 0x1234; DIV -5/0 -> 0xFFFFFFFF.
4. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, latency 1; REM same operands -> 0.
5. Flush asserted in RUN cycle 10 -> no done, ready=1 next cycle, Result unchanged. Then DIVU 50/5 -> 10 with normal latency. Also flush and start in the same cycle -> start not accepted.
6. Start DIVU 9/2 asserted during DONE of a prior op -> prior done pulses, new op done 34 cycles later with Result 4. Separately, reset dropped mid-RUN -> ready=1, busy=0, done=0, Result=0 immediately, before any clock edge.
